stream_sorter: RTL

//  Packet sorter: receives a packet of up to 2**AWIDTH words on a valid/ready

---
 rtl/stream_sorter_pkg.sv | 19 +
 rtl/stream_sorter_if.sv | 15 +
 rtl/stream_sorter_cmp_swap.sv | 19 +
 rtl/stream_sorter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/stream_sorter_pkg.sv
// Shared types and helpers for the stream sorter.
// Contents: FSM state encoding, widest supported data word, pair-order test.
// Imported by the compare/swap cell and the sorter top.
package stream_sorter_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, SORT, READ} state_t;

  // Widest data word the order test accepts; narrower words are zero-extended.
  localparam int MAX_DWIDTH = 32;

  // True when a (lower address) and b (next address) must be exchanged.
  // Equal values never swap, which keeps the sort stable.
  function automatic logic out_of_order(input logic [MAX_DWIDTH-1:0] a,
                                        input logic [MAX_DWIDTH-1:0] b,
                                        input logic                  descend);
    return descend ? (a < b) : (a > b);
  endfunction

endpackage

// File: rtl/stream_sorter_if.sv
// Valid/ready word stream with SOP/EOP packet framing.
// Signals: data, sop, eop, valid (producer -> consumer), ready (consumer -> producer).
// master = producer side, slave = consumer side.
interface stream_sorter_if #(
  parameter int DWIDTH = 8
);
  logic [DWIDTH-1:0] data;
  logic              sop;
  logic              eop;
  logic              valid;
  logic              ready;

  modport master (output data, sop, eop, valid, input ready);
  modport slave  (input data, sop, eop, valid, output ready);
endinterface

// File: rtl/stream_sorter_cmp_swap.sv
// Combinational compare/swap of one adjacent pair, unsigned compare.
// Ports: a, b (pair in address order), descend (direction), first/second (pair
// after optional exchange), swap (exchange happened).
module sorter_cmp_swap
  import stream_sorter_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  logic              descend,
  output logic [DWIDTH-1:0] first,
  output logic [DWIDTH-1:0] second,
  output logic              swap
);
  assign swap   = out_of_order(MAX_DWIDTH'(a), MAX_DWIDTH'(b), descend);
  assign first  = swap ? b : a;
  assign second = swap ? a : b;
endmodule

// File: rtl/stream_sorter.sv
// Packet sorter: captures up to 2**AWIDTH words, bubble-sorts them in place
// (one compare/swap per clock), then replays them with SOP/EOP framing.
// Ports: clk_i, arst_n_i, snk (word stream in), src (sorted stream out),
// descend_i (direction, sampled with SOP), busy_o (not IDLE), overflow_o (truncation pulse).
module stream_sorter
  import stream_sorter_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic           clk_i,
  input  logic           arst_n_i,
  stream_sorter_if.slave  snk,
  stream_sorter_if.master src,
  input  logic           descend_i,
  output logic           busy_o,
  output logic           overflow_o
);
  localparam int MAXLEN = 2**AWIDTH;

  state_t             state, state_nxt;
  logic [DWIDTH-1:0]  mem [MAXLEN];
  logic [AWIDTH:0]    len;
  logic [AWIDTH-1:0]  wr, rd, j, pass;
  logic               descend, swapped;

  logic               acc, last_wr, pass_end, sort_done, rd_last;
  logic [AWIDTH-1:0]  j_nxt;
  logic [DWIDTH-1:0]  cs_first, cs_second;
  logic               cs_swap;

  assign acc     = snk.valid & snk.ready;
  assign last_wr = (wr == AWIDTH'(MAXLEN - 1));
  assign j_nxt   = j + AWIDTH'(1);
  // The last compare of a pass sits at j == len-2-pass.
  assign pass_end  = ({1'b0, j} == len - (AWIDTH+1)'(2) - {1'b0, pass});
  assign sort_done = pass_end & (~(swapped | cs_swap) |
                                 ({1'b0, pass} == len - (AWIDTH+1)'(2)));
  assign rd_last   = ({1'b0, rd} == len - (AWIDTH+1)'(1));

  sorter_cmp_swap #(.DWIDTH(DWIDTH)) u_cmp_swap (
    .a       (mem[j]),
    .b       (mem[j_nxt]),
    .descend (descend),
    .first   (cs_first),
    .second  (cs_second),
    .swap    (cs_swap)
  );

  // Ready is masked by reset so every output reads 0 while reset is held.
  assign snk.ready = arst_n_i & ((state == IDLE) | (state == WRITE));
  assign busy_o    = (state != IDLE);
  assign src.valid = (state == READ);
  assign src.data  = (state == READ) ? mem[rd] : '0;
  assign src.sop   = (state == READ) & (rd == '0);
  assign src.eop   = (state == READ) & rd_last;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, WRITE: begin
        if (acc) begin
          if (snk.sop)                         state_nxt = snk.eop ? READ : WRITE;
          else if (state == WRITE && (snk.eop || last_wr)) state_nxt = SORT;
        end
      end
      SORT:    if (sort_done) state_nxt = READ;
      READ:    if (src.ready && rd_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < MAXLEN; i++) mem[i] <= '0;
      len        <= '0;
      wr         <= '0;
      rd         <= '0;
      j          <= '0;
      pass       <= '0;
      descend    <= 1'b0;
      swapped    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= 1'b0;
      case (state)
        IDLE, WRITE: begin
          if (acc) begin
            if (snk.sop) begin
              // A SOP always (re)starts the packet, discarding any partial one.
              mem[0]  <= snk.data;
              descend <= descend_i;
              wr      <= AWIDTH'(1);
              len     <= (AWIDTH+1)'(1);
            end else if (state == WRITE) begin
              mem[wr] <= snk.data;
              wr      <= wr + AWIDTH'(1);
              len     <= {1'b0, wr} + (AWIDTH+1)'(1);
              if (!snk.eop && last_wr) overflow_o <= 1'b1;
            end
          end
        end
        SORT: begin
          if (cs_swap) begin
            mem[j]     <= cs_first;
            mem[j_nxt] <= cs_second;
          end
          if (pass_end) begin
            j       <= '0;
            swapped <= 1'b0;
            pass    <= sort_done ? '0 : pass + AWIDTH'(1);
          end else begin
            j       <= j_nxt;
            swapped <= swapped | cs_swap;
          end
        end
        READ: begin
          if (src.ready) rd <= rd_last ? '0 : rd + AWIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
